// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [10:0] IM_BASE_WIDX = 11'h400;
    localparam int          IM_WORDS     = 2048;

    localparam int BYTE_W = 8;
    localparam int LEN_W  = 16;
    localparam int WORD_W = 32;
    localparam int WIDX_W = 12;
    localparam int ADDR_W = 11;

endpackage

// File: rtl/byte_packer.sv
// Packs four consecutive bytes, MSB first, into a 32-bit word.
module byte_packer
    import loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                strobe,
    input  logic [BYTE_W-1:0]   data,
    output logic                word_done,
    output logic [WORD_W-1:0]   word
);

    logic [1:0]  cnt;
    logic [23:0] sr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
            sr  <= '0;
        end else if (strobe) begin
            cnt <= cnt + 2'd1;
            sr  <= {sr[15:0], data};
        end
    end

    // The fourth byte completes the word in the same cycle it is presented.
    assign word_done = strobe && (cnt == 2'd3);
    assign word      = {sr, data};

endmodule

// File: rtl/im_loader.sv
// Framed byte-stream loader that writes the instruction memory and releases the CPU after a verified image.
module im_loader
    import loader_pkg::*;
#(
    parameter logic [10:0] BASE_WIDX = IM_BASE_WIDX,
    parameter int          MAX_WORDS = IM_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        im_we,
    output logic [10:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold
);

    state_t state, state_nx;

    logic [BYTE_W-1:0] len_hi;
    logic [WIDX_W-1:0] len;
    logic [WIDX_W-1:0] widx;
    logic [BYTE_W-1:0] csum;
    logic [LEN_W-1:0]  n;
    logic              accept;
    logic              start_go;
    logic              data_strobe;
    logic              word_done;
    logic [WORD_W-1:0] word;
    logic              last_word;
    logic              rdy_nx, busy_nx, done_nx, error_nx, hold_nx;

    assign accept      = rx_valid && rx_ready;
    assign start_go    = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign data_strobe = accept && (state == ST_DATA);
    assign n           = {len_hi, rx_data};
    assign last_word   = (widx + 12'd1) == len;

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_go),
        .strobe    (data_strobe),
        .data      (rx_data),
        .word_done (word_done),
        .word      (word)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: if (start) state_nx = ST_LEN_HI;
            ST_LEN_HI: if (accept) state_nx = ST_LEN_LO;
            ST_LEN_LO: begin
                if (accept) begin
                    if (n == '0 || n > LEN_W'(MAX_WORDS)) state_nx = ST_ERR;
                    else                                  state_nx = ST_DATA;
                end
            end
            ST_DATA: if (word_done && last_word) state_nx = ST_CSUM;
            ST_CSUM: begin
                if (accept) state_nx = (rx_data == csum) ? ST_DONE : ST_ERR;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Status flags are decoded from the next state and registered alongside it.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rdy_nx   = 1'b0;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        error_nx = 1'b0;
        hold_nx  = 1'b1;
        case (state_nx)
            ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CSUM: begin
                rdy_nx  = 1'b1;
                busy_nx = 1'b1;
            end
            ST_DONE: begin
                done_nx = 1'b1;
                hold_nx = 1'b0;
            end
            ST_ERR:  error_nx = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            rx_ready <= rdy_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            error    <= error_nx;
            cpu_hold <= hold_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_hi   <= '0;
            len      <= '0;
            widx     <= '0;
            csum     <= '0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
        end else begin
            im_we <= data_strobe && word_done;
            if (start_go) begin
                widx <= '0;
                csum <= '0;
            end
            if (accept && state == ST_LEN_HI) len_hi <= rx_data;
            if (accept && state == ST_LEN_LO) len    <= n[WIDX_W-1:0];
            if (data_strobe) begin
                csum <= csum ^ rx_data;
                if (word_done) begin
                    widx     <= widx + 12'd1;
                    // Address wraps modulo the 2048-word memory.
                    im_addr  <= ADDR_W'({1'b0, BASE_WIDX} + widx);
                    im_wdata <= word;
                end
            end
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: cycle vector table plus multi-cycle frame sequences.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        rst, start, rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready, im_we, busy, done, error, cpu_hold;
    logic [10:0] im_addr;
    logic [31:0] im_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    im_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, start, vld;
        logic [7:0]  d;
        logic        rdy, we;
        logic [10:0] addr;
        logic [31:0] wd;
        logic        busy, done, err, hold;
    } vec_t;

    vec_t vt[18];

    logic [10:0] wr_addr[$];
    logic [31:0] wr_data[$];

    always @(negedge clk) begin
        if (im_we) begin
            wr_addr.push_back(im_addr);
            wr_data.push_back(im_wdata);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic v, input logic [7:0] d,
                                input logic rdy, input logic we, input logic [10:0] a,
                                input logic [31:0] wd, input logic b, input logic dn,
                                input logic e, input logic h);
        vec_t x;
        x.rst = r; x.start = s; x.vld = v; x.d = d;
        x.rdy = rdy; x.we = we; x.addr = a; x.wd = wd;
        x.busy = b; x.done = dn; x.err = e; x.hold = h;
        return x;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        start = 1'b0; rx_valid = 1'b1; rx_data = b;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1; rx_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
    endtask

    initial begin
        logic [31:0] w;
        logic [7:0]  cs;
        int          bad;
        logic [7:0]  two[10];

        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

        //         rst st vld data   rdy we addr    wdata         busy dn er hold
        vt[0]  = mk(1, 0, 0, 8'h00,  0, 0, 11'h000, 32'h0,        0, 0, 0, 1);
        vt[1]  = mk(0, 1, 0, 8'h00,  1, 0, 11'h000, 32'h0,        1, 0, 0, 1);
        vt[2]  = mk(0, 0, 1, 8'h00,  1, 0, 11'h000, 32'h0,        1, 0, 0, 1);
        vt[3]  = mk(0, 0, 1, 8'h01,  1, 0, 11'h000, 32'h0,        1, 0, 0, 1);
        vt[4]  = mk(0, 0, 1, 8'h12,  1, 0, 11'h000, 32'h0,        1, 0, 0, 1);
        vt[5]  = mk(0, 0, 1, 8'h34,  1, 0, 11'h000, 32'h0,        1, 0, 0, 1);
        vt[6]  = mk(0, 0, 1, 8'h56,  1, 0, 11'h000, 32'h0,        1, 0, 0, 1);
        vt[7]  = mk(0, 0, 1, 8'h78,  1, 1, 11'h400, 32'h12345678, 1, 0, 0, 1);
        vt[8]  = mk(0, 0, 1, 8'h08,  0, 0, 11'h400, 32'h12345678, 0, 1, 0, 0);
        vt[9]  = mk(0, 0, 0, 8'h00,  0, 0, 11'h400, 32'h12345678, 0, 1, 0, 0);
        vt[10] = mk(0, 1, 0, 8'h00,  1, 0, 11'h400, 32'h12345678, 1, 0, 0, 1);
        vt[11] = mk(0, 0, 1, 8'h00,  1, 0, 11'h400, 32'h12345678, 1, 0, 0, 1);
        vt[12] = mk(0, 0, 1, 8'h00,  0, 0, 11'h400, 32'h12345678, 0, 0, 1, 1);
        vt[13] = mk(0, 1, 0, 8'h00,  1, 0, 11'h400, 32'h12345678, 1, 0, 0, 1);
        vt[14] = mk(0, 0, 1, 8'h08,  1, 0, 11'h400, 32'h12345678, 1, 0, 0, 1);
        vt[15] = mk(0, 0, 1, 8'h01,  0, 0, 11'h400, 32'h12345678, 0, 0, 1, 1);
        vt[16] = mk(0, 0, 1, 8'h55,  0, 0, 11'h400, 32'h12345678, 0, 0, 1, 1);
        vt[17] = mk(1, 1, 0, 8'h00,  0, 0, 11'h000, 32'h0,        0, 0, 0, 1);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rst = vt[i].rst; start = vt[i].start; rx_valid = vt[i].vld; rx_data = vt[i].d;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  64'({rx_ready, im_we, im_addr, im_wdata, busy, done, error, cpu_hold}),
                  64'({vt[i].rdy, vt[i].we, vt[i].addr, vt[i].wd,
                       vt[i].busy, vt[i].done, vt[i].err, vt[i].hold}));
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; rx_valid = 1'b0;

        // Two-word frame with random idle gaps between bytes.
        wr_addr.delete(); wr_data.delete();
        two = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01};
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            send_byte(two[i]);
            idle($urandom_range(0, 3));
        end
        send_byte(8'h23);
        idle(1);
        check("two_cnt", 64'(wr_addr.size()), 64'd2);
        if (wr_addr.size() == 2) begin
            check("two_w0", {21'h0, wr_addr[0], wr_data[0]}, {21'h0, 11'h400, 32'hDEADBEEF});
            check("two_w1", {21'h0, wr_addr[1], wr_data[1]}, {21'h0, 11'h401, 32'h00000001});
        end
        check("two_stat", 64'({busy, done, error, cpu_hold}), 64'b0100);

        // Bad checksum: the write still lands, then error is reported.
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h01); send_word(32'h12345678); send_byte(8'h09);
        idle(1);
        check("bcs_cnt", 64'(wr_addr.size()), 64'd1);
        check("bcs_stat", 64'({rx_ready, busy, done, error, cpu_hold}), 64'b00011);
        pulse_start();
        check("bcs_clr", 64'({busy, done, error}), 64'b100);
        send_byte(8'h00); send_byte(8'h01); send_word(32'h12345678); send_byte(8'h08);
        idle(1);
        check("bcs_rec", 64'({busy, done, error, cpu_hold}), 64'b0100);

        // Full 2048-word image: addresses wrap from 0x7FF to 0x000.
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        send_byte(8'h08); send_byte(8'h00);
        cs = 8'h00;
        for (int i = 0; i < 2048; i++) begin
            w = 32'hA500_0000 | 32'(i);
            cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            send_word(w);
        end
        send_byte(cs);
        idle(1);
        check("full_cnt", 64'(wr_addr.size()), 64'd2048);
        bad = 0;
        if (wr_addr.size() == 2048) begin
            for (int i = 0; i < 2048; i++) begin
                if (wr_addr[i] !== 11'((11'h400 + i) % 2048) || wr_data[i] !== (32'hA500_0000 | 32'(i)))
                    bad++;
            end
            check("full_first", 64'(wr_addr[0]), 64'h400);
            check("full_wrap", 64'(wr_addr[1024]), 64'h000);
            check("full_last", 64'(wr_addr[2047]), 64'h3FF);
        end
        check("full_words", 64'(bad), 64'd0);
        check("full_stat", 64'({busy, done, error, cpu_hold}), 64'b0100);

        // Rerun aborted by a 2-cycle reset after 5 payload bytes.
        wr_addr.delete(); wr_data.delete();
        pulse_start();
        send_byte(8'h08); send_byte(8'h00);
        send_word(32'hCAFEF00D);
        send_byte(8'h11);
        @(negedge clk);
        rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h22;
        @(negedge clk);
        rx_data = 8'h33;
        @(negedge clk);
        rst = 1'b0; rx_valid = 1'b0;
        check("rst_cnt", 64'(wr_addr.size()), 64'd1);
        if (wr_addr.size() == 1)
            check("rst_w0", {21'h0, wr_addr[0], wr_data[0]}, {21'h0, 11'h400, 32'hCAFEF00D});
        check("rst_out", 64'({rx_ready, im_we, im_addr, im_wdata, busy, done, error, cpu_hold}),
              64'({1'b0, 1'b0, 11'h000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1}));
        idle(3);
        check("rst_idle", 64'({rx_ready, busy, cpu_hold}), 64'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
